// File: rtl/fir_serial_mac.sv
// Time-multiplexed FIR filter: one multiply-accumulate per cycle, N_TAPS+2 cycles per sample,
// runtime-loadable coefficients, arithmetic-shift rounding and saturating output.
module fir_serial_mac #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COEF_W = 11,
  parameter int unsigned N_TAPS = 32,
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned SHIFT  = 0,
  parameter int unsigned OUT_W  = 32,
  localparam int unsigned AddrW = $clog2(N_TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              coef_we,
  input  logic [AddrW-1:0]  coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              coef_err,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat
);

  localparam int unsigned ProdW = DATA_W + COEF_W;
  localparam logic signed [ACC_W-1:0] MaxOut = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MinOut = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

  state_e                    state_q;
  logic signed [DATA_W-1:0]  dly_q [N_TAPS];
  logic signed [COEF_W-1:0]  coef_q [N_TAPS];
  logic signed [ACC_W-1:0]   acc_q;
  logic        [AddrW-1:0]   idx_q;
  logic                      out_valid_q, out_sat_q, coef_err_q;
  logic        [OUT_W-1:0]   out_data_q;

  logic signed [ProdW-1:0]   prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   shifted;
  logic                      addr_ok;

  always_comb begin
    prod     = dly_q[idx_q] * coef_q[idx_q];
    prod_ext = {{(ACC_W-ProdW){prod[ProdW-1]}}, prod};
    shifted  = acc_q >>> SHIFT;
    addr_ok  = 32'(coef_addr) < N_TAPS;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      for (int k = 0; k < int'(N_TAPS); k++) begin
        dly_q[k]  <= '0;
        coef_q[k] <= '0;
      end
      acc_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
      coef_err_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= 1'b0;
      coef_err_q  <= 1'b0;
      // Coefficients may only change while no computation is reading them.
      if (coef_we) begin
        if (state_q == StIdle && addr_ok) coef_q[coef_addr] <= coef_data;
        else                              coef_err_q        <= 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            for (int k = int'(N_TAPS) - 1; k > 0; k--) dly_q[k] <= dly_q[k-1];
            dly_q[0] <= in_data;
            acc_q    <= '0;
            idx_q    <= '0;
            state_q  <= StMac;
          end
        end
        StMac: begin
          acc_q <= acc_q + prod_ext;
          idx_q <= idx_q + AddrW'(1);
          if (idx_q == AddrW'(N_TAPS - 1)) state_q <= StDone;
        end
        StDone: begin
          if (shifted > MaxOut) begin
            out_data_q <= MaxOut[OUT_W-1:0];
            out_sat_q  <= 1'b1;
          end else if (shifted < MinOut) begin
            out_data_q <= MinOut[OUT_W-1:0];
            out_sat_q  <= 1'b1;
          end else begin
            out_data_q <= shifted[OUT_W-1:0];
            out_sat_q  <= 1'b0;
          end
          out_valid_q <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign coef_err  = coef_err_q;

endmodule

// File: tb/tb_fir_serial_mac.sv
// Bench for fir_serial_mac: three parameterisations share one stimulus stream and are checked
// every cycle against a sample-level convolution model, plus literal expectations per scenario.
module tb_fir_serial_mac;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        coef_we = 1'b0;
  logic [4:0]  coef_addr = '0;
  logic [10:0] coef_data = '0;

  logic        r0, r1, r2, e0, e1, e2, v0, v1, v2, s0, s1, s2;
  logic [31:0] d0, d2;
  logic [15:0] d1;

  fir_serial_mac #(.SHIFT(0), .OUT_W(32)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r0), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(e0),
    .out_valid(v0), .out_data(d0), .out_sat(s0));
  fir_serial_mac #(.SHIFT(0), .OUT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r1), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(e1),
    .out_valid(v1), .out_data(d1), .out_sat(s1));
  fir_serial_mac #(.SHIFT(4), .OUT_W(32)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r2), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(e2),
    .out_valid(v2), .out_data(d2), .out_sat(s2));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sample-level model: history + coefficient arrays, expected results queued with due edge.
  typedef struct {longint acc; longint due;} exp_t;
  exp_t   q[$];
  longint coef_m[N];
  longint hist_m[N];
  longint edge_n = 0, ready_at = 0, acc_m;
  bit     live = 0, idle_m, exp_err = 0, exp_vld = 0, exp_rdy = 1;
  longint held_d[3];
  bit     held_s[3];
  int     shift_p[3] = '{0, 0, 4};
  int     outw_p[3]  = '{32, 16, 32};

  function automatic void round_sat(input longint acc, input int sh, input int ow,
                                    output longint d, output bit s);
    longint r, mx, mn;
    r  = acc >>> sh;
    mx = (longint'(1) <<< (ow - 1)) - 1;
    mn = -(longint'(1) <<< (ow - 1));
    if (r > mx)      begin d = mx; s = 1; end
    else if (r < mn) begin d = mn; s = 1; end
    else             begin d = r;  s = 0; end
  endfunction

  always @(posedge clk) begin
    exp_err = 0;
    exp_vld = 0;
    if (rst) begin
      for (int k = 0; k < N; k++) begin coef_m[k] = 0; hist_m[k] = 0; end
      for (int i = 0; i < 3; i++) begin held_d[i] = 0; held_s[i] = 0; end
      q.delete();
      ready_at = edge_n + 1;
      live = 1;
    end else begin
      idle_m = edge_n >= ready_at;
      if (coef_we) begin
        if (idle_m && int'(coef_addr) < N) coef_m[coef_addr] = longint'($signed(coef_data));
        else exp_err = 1;
      end
      if (q.size() > 0 && q[0].due == edge_n) begin
        exp_vld = 1;
        for (int i = 0; i < 3; i++) round_sat(q[0].acc, shift_p[i], outw_p[i], held_d[i], held_s[i]);
        void'(q.pop_front());
      end
      if (in_valid && idle_m) begin
        for (int k = N - 1; k > 0; k--) hist_m[k] = hist_m[k-1];
        hist_m[0] = longint'($signed(in_data));
        acc_m = 0;
        for (int k = 0; k < N; k++) acc_m += hist_m[k] * coef_m[k];
        q.push_back('{acc_m, edge_n + N + 1});
        ready_at = edge_n + N + 2;
      end
    end
    exp_rdy = (edge_n + 1) >= ready_at;
    edge_n++;
  end

  longint cap0[$], cap1[$], cap2[$];
  bit     caps0[$], caps1[$], caps2[$];

  always @(negedge clk) begin
    if (live) begin
      chk("valid0", longint'(v0), longint'(exp_vld));
      chk("valid1", longint'(v1), longint'(exp_vld));
      chk("valid2", longint'(v2), longint'(exp_vld));
      chk("ready0", longint'(r0), longint'(exp_rdy));
      chk("ready1", longint'(r1), longint'(exp_rdy));
      chk("ready2", longint'(r2), longint'(exp_rdy));
      chk("err0", longint'(e0), longint'(exp_err));
      chk("err1", longint'(e1), longint'(exp_err));
      chk("err2", longint'(e2), longint'(exp_err));
      chk("data0", longint'($signed(d0)), held_d[0]);
      chk("data1", longint'($signed(d1)), held_d[1]);
      chk("data2", longint'($signed(d2)), held_d[2]);
      chk("sat0", longint'(s0), longint'(held_s[0]));
      chk("sat1", longint'(s1), longint'(held_s[1]));
      chk("sat2", longint'(s2), longint'(held_s[2]));
      if (v0) begin cap0.push_back(longint'($signed(d0))); caps0.push_back(s0); end
      if (v1) begin cap1.push_back(longint'($signed(d1))); caps1.push_back(s1); end
      if (v2) begin cap2.push_back(longint'($signed(d2))); caps2.push_back(s2); end
    end
  end

  task automatic clear_caps();
    cap0.delete(); cap1.delete(); cap2.delete();
    caps0.delete(); caps1.delete(); caps2.delete();
  endtask

  task automatic send(input logic [15:0] x);
    int guard = 0;
    bit acc;
    in_valid = 1'b1;
    in_data  = x;
    while (1) begin
      acc = r0;
      @(posedge clk);
      if (acc || guard > 200) break;
      #1;
      guard++;
    end
    #1 in_valid = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic write_coef(input int addr, input int val);
    coef_we   = 1'b1;
    coef_addr = addr[4:0];
    coef_data = val[10:0];
    @(posedge clk);
    #1 coef_we = 1'b0;
  endtask

  task automatic idle_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int lp_half[16] = '{-17, -20, -15, 10, 50, 110, 190, 290, 410, 540, 680, 800, 944, 970, 1010, 1023};
  int cnt, sz;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_data0", longint'(d0), 0);
    chk("reset_ready0", longint'(r0), 1);
    chk("reset_valid0", longint'(v0), 0);

    // Impulse through ramp coefficients.
    for (int k = 0; k < N; k++) write_coef(k, k + 1);
    clear_caps();
    send(16'd100);
    for (int k = 0; k < N; k++) send(16'd0);
    idle_wait(40);
    chk("imp_count", cap0.size(), 33);
    for (int k = 0; k < N && k < cap0.size(); k++) chk("imp_val", cap0[k], 100 * (k + 1));
    if (cap0.size() == 33) chk("imp_tail", cap0[32], 0);
    for (int k = 0; k < caps0.size(); k++) chk("imp_sat", caps0[k], 0);

    // Symmetric lowpass, step of 1000.
    for (int k = 0; k < N; k++) write_coef(k, (k < 16) ? lp_half[k] : lp_half[31 - k]);
    clear_caps();
    for (int k = 0; k < 40; k++) send(16'd1000);
    idle_wait(40);
    chk("lp_count", cap0.size(), 40);
    for (int k = 31; k < cap0.size(); k++) chk("lp_settled", cap0[k], 13950000);

    // Saturation on the 16-bit output instance.
    for (int k = 0; k < N; k++) write_coef(k, 1023);
    clear_caps();
    for (int k = 0; k < N; k++) send(16'sd32767);
    idle_wait(40);
    if (cap1.size() > 0) begin
      chk("satp_data1", cap1[$], 32767);
      chk("satp_flag1", caps1[$], 1);
      chk("satp_data0", cap0[$], 1072660512);
      chk("satp_flag0", caps0[$], 0);
    end else chk("satp_none", 0, 1);
    clear_caps();
    for (int k = 0; k < N; k++) send(16'h8000);
    idle_wait(40);
    if (cap1.size() > 0) begin
      chk("satn_data1", cap1[$], -32768);
      chk("satn_flag1", caps1[$], 1);
    end else chk("satn_none", 0, 1);

    // Arithmetic shift rounds toward minus infinity.
    write_coef(0, 1);
    for (int k = 1; k < N; k++) write_coef(k, 0);
    clear_caps();
    send(-16'sd33);
    idle_wait(40);
    if (cap2.size() == 1) begin
      chk("shift_data2", cap2[0], -3);
      chk("shift_flag2", caps2[0], 0);
    end else chk("shift_count", cap2.size(), 1);

    // Write during MAC is dropped; old coefficient stays in effect.
    clear_caps();
    send(16'd10);
    write_coef(0, 7);
    chk("busy_write_err", longint'(e0), 1);
    idle_wait(40);
    send(16'd20);
    idle_wait(40);
    if (cap0.size() == 2) begin
      chk("busy_cur", cap0[0], 10);
      chk("busy_next", cap0[1], 20);
    end else chk("busy_count", cap0.size(), 2);
    write_coef(31, 5);
    chk("idle_write_err", longint'(e0), 0);

    // Reset mid-computation discards the result and clears the delay line.
    clear_caps();
    send(16'd7);
    idle_wait(9);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    idle_wait(40);
    chk("rst_no_valid", cap0.size(), 0);
    write_coef(0, 2);
    send(16'd5);
    cnt = 0;
    while (!v0 && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    // out_valid is registered on the (N+1)th edge after accept, so it is seen in cycle N+2.
    chk("latency_edges", cnt, N + 1);
    chk("latency_ready", longint'(r0), 1);
    chk("rst_impulse", longint'($signed(d0)), 10);
    idle_wait(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_serial_mac.md
Name: fir_serial_mac

Overview:
- Parametrised successor to the team's fully parallel 32-tap lowpass FIR, built around a single time-multiplexed multiply-accumulate unit.
- Processes one input sample per N_TAPS+2 cycles under a valid/ready handshake.
- Coefficients are runtime-loadable instead of hard-wired.
- Output is rounded by a fixed arithmetic shift and saturated, with a saturation flag.
- Sits between the sample source (ADC/decimator) and downstream DSP stages where multiplier count matters more than throughput.

Parameters:
- DATA_W, 16, signed input sample width
- COEF_W, 11, signed coefficient width
- N_TAPS, 32, number of taps (>=2)
- ACC_W, 40, accumulator width; must be >= DATA_W+COEF_W+clog2(N_TAPS)
- SHIFT, 0, arithmetic right shift applied to the accumulator before output
- OUT_W, 32, signed output width (<= ACC_W)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_data  in  DATA_W  signed input sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(N_TAPS)  coefficient index (tap 0 multiplies the newest sample)
- coef_data  in  COEF_W  signed coefficient value
- coef_err  out  1  one-cycle pulse: write dropped (busy or address out of range)
- out_valid  out  1  one-cycle pulse, out_data/out_sat valid
- out_data  out  OUT_W  signed filtered sample
- out_sat  out  1  out_data was clamped

Behaviour:
- One clock domain; reset is synchronous and active-high. On rst=1 at a clock edge:
  - state<=IDLE; all delay-line entries and coefficients <=0.
  - out_valid, out_sat, coef_err <=0; out_data<=0.
  - Reset overrides any operation in progress; the partial result is discarded and no out_valid is produced.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready: d[k]<=d[k-1] for k=N_TAPS-1..1, d[0]<=in_data, acc<=0, idx<=0, go to MAC.
  - MAC: in_ready=0. Each cycle: acc<=acc+sext(d[idx]*c[idx]); idx<=idx+1. After the cycle with idx==N_TAPS-1, go to DONE. Exactly N_TAPS MAC cycles.
  - DONE: in_ready=0. Registers r=acc>>>SHIFT (arithmetic). If r>2^(OUT_W-1)-1, out_data<=max and out_sat<=1. If r<-2^(OUT_W-1), out_data<=min and out_sat<=1. Otherwise out_data<=r[OUT_W-1:0] and out_sat<=0. out_valid<=1. Go to IDLE.
- Timing:
  - The accept edge is cycle 0; out_valid is high in cycle N_TAPS+2 for exactly one cycle, simultaneously with in_ready=1.
  - A sample accepted in that same cycle starts the next computation with no bubble. Throughput is 1 sample / (N_TAPS+2) cycles.
- out_data and out_sat hold their value until the next DONE; only out_valid qualifies them.
- Products are full width (DATA_W+COEF_W signed), sign-extended to ACC_W. The accumulator never wraps, given the ACC_W constraint.
- Coefficient writes:
  - Applied only in IDLE, with c[coef_addr]<=coef_data at that edge.
  - A write in IDLE is visible to a sample accepted in the same cycle, since the MAC reads it in later cycles.
  - A write in MAC/DONE, or with coef_addr>=N_TAPS, is dropped and coef_err pulses for one cycle. Coefficients are unchanged.
- in_valid while in_ready=0 is ignored (no sample consumed); the source must hold the sample.
- in_data is sampled only on the accept edge.

Test Plan:
- Reset then impulse, with default params: load c[k]=k+1 for k=0..31; send 100 then 32 zeros back-to-back -> out_data sequence 100,200,...,3200, then 0. Each out_valid occurs 34 cycles after its accept. out_sat=0 throughout.
- Lowpass coefficients (symmetric set -17,-20,...,1023,1023,...,-17), step input 1000 held for 40 samples -> settles at 1000*sum(c)=1000*13950=13950000, and stays there.
- Saturation, with OUT_W=16, SHIFT=0: c[0..31]=1023, input 32767 x32 -> out_data=32767, out_sat=1. With input -32768 x32 -> out_data=-32768, out_sat=1.
- SHIFT=4, c[0]=1 and others 0, input -33 -> out_data=-3 (arithmetic floor), out_sat=0.
- Coefficient write during MAC -> coef_err pulses, current and next outputs use the old coefficient. A write with coef_addr=31 in IDLE succeeds with coef_err=0.
- Assert rst at MAC cycle 10 -> no out_valid. After release, an impulse of 5 with c[0]=2 (others 0) -> out_data=10, confirming the delay line was cleared.
